// File: rtl/video_fifo_pixel_out.sv
// Pixel-clock output stage: video timing, FIFO read issue, RGB565->RGB888 and underflow tracking.
// Define TEST_PATTERN_EN to add the colour-bar generator selected by test_mode.
module video_fifo_pixel_out #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic        rd_clk,
   input  logic        rd_rst_n,
   output logic        rd_en,
   input  logic [15:0] rd_data,
   input  logic        rd_empty,
   output logic        frame_req,
   input  logic        test_mode,
   input  logic        underflow_clr,
   output logic        vid_hs,
   output logic        vid_vs,
   output logic        vid_de,
   output logic [23:0] vid_rgb,
   output logic        underflow,
   output logic [15:0] underflow_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // One spare bit so every region boundary, totals included, fits the counter width.
   localparam int HW = $clog2(H_TOTAL + 1);
   localparam int VW = $clog2(V_TOTAL + 1);

   localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

   logic [HW-1:0] h_cnt_reg, h_cnt_next;
   logic [VW-1:0] v_cnt_reg, v_cnt_next;
   logic          act, hs_raw, vs_raw, miss, pattern_on;

   logic          s1_hit_reg, s1_de_reg, s1_hs_reg, s1_vs_reg;
   logic          vid_hs_reg, vid_vs_reg, vid_de_reg;
   logic [23:0]   vid_rgb_reg, rgb_next, rgb_expand, rgb_pattern;
   logic          underflow_reg;
   logic [15:0]   underflow_cnt_reg;

   // ---------------------------------------------------------------- timing
   always_comb begin
      h_cnt_next = h_cnt_reg + 1'b1;
      v_cnt_next = v_cnt_reg;
      if (h_cnt_reg == H_LAST) begin
         h_cnt_next = '0;
         v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
      end
   end

   // Reset parks the raster at the start of vertical blanking so a new frame is requested at once.
   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         h_cnt_reg <= '0;
         v_cnt_reg <= V_ACT_END;
      end else begin
         h_cnt_reg <= h_cnt_next;
         v_cnt_reg <= v_cnt_next;
      end
   end

   assign act    = (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
   assign hs_raw = (h_cnt_reg >= H_SYNC_BEG) && (h_cnt_reg < H_SYNC_END);
   assign vs_raw = (v_cnt_reg >= V_SYNC_BEG) && (v_cnt_reg < V_SYNC_END);

   assign rd_en     = act && !rd_empty && !pattern_on;
   assign miss      = act && rd_empty && !pattern_on;
   assign frame_req = rd_rst_n && (h_cnt_reg == '0) && (v_cnt_reg == V_ACT_END);

   // ---------------------------------------------------------- test pattern
`ifdef TEST_PATTERN_EN
   logic        pattern_on_reg;
   logic        s1_pat_reg;
   logic [2:0]  s1_bar_reg, bar_idx;
   logic [6:0]  bar_thr;
   logic [23:0] bar_lut [8];

   // Bar index h*8/H_ACTIVE as a count of crossed thresholds, avoiding a divider.
   genvar gi;
   generate
      for (gi = 1; gi < 8; gi++) begin : g_bar_thr
         assign bar_thr[gi-1] = {h_cnt_reg, 3'b000} >= (HW+3)'(gi * H_ACTIVE);
      end
      // white, yellow, cyan, green, magenta, red, blue, black
      for (gi = 0; gi < 8; gi++) begin : g_bar_lut
         localparam logic [2:0] IDX = 3'(gi);
         assign bar_lut[gi] = {{8{~IDX[1]}}, {8{~IDX[2]}}, {8{~IDX[0]}}};
      end
   endgenerate

   always_comb begin
      bar_idx = '0;
      for (int i = 0; i < 7; i++) begin
         bar_idx = bar_idx + 3'(bar_thr[i]);
      end
   end

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         pattern_on_reg <= 1'b0;
         s1_pat_reg     <= 1'b0;
         s1_bar_reg     <= '0;
      end else begin
         if (frame_req) begin
            pattern_on_reg <= test_mode;
         end
         s1_pat_reg <= act && pattern_on_reg;
         s1_bar_reg <= bar_idx;
      end
   end

   assign pattern_on  = pattern_on_reg;
   assign rgb_pattern = s1_pat_reg ? bar_lut[s1_bar_reg] : 24'h000000;
`else
   logic unused_test_mode;
   assign unused_test_mode = test_mode;
   assign pattern_on       = 1'b0;
   assign rgb_pattern      = 24'h000000;
`endif

   // -------------------------------------------------------------- pipeline
   assign rgb_expand = {rd_data[15:11], rd_data[15:13],
                        rd_data[10:5],  rd_data[10:9],
                        rd_data[4:0],   rd_data[4:2]};

   // A missed slot carries no hit and no pattern, so it falls through to black.
   assign rgb_next = s1_hit_reg ? rgb_expand : rgb_pattern;

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         s1_hit_reg  <= 1'b0;
         s1_de_reg   <= 1'b0;
         s1_hs_reg   <= 1'b0;
         s1_vs_reg   <= 1'b0;
         vid_de_reg  <= 1'b0;
         vid_hs_reg  <= ~SYNC_POL;
         vid_vs_reg  <= ~SYNC_POL;
         vid_rgb_reg <= '0;
      end else begin
         s1_hit_reg  <= rd_en;
         s1_de_reg   <= act;
         s1_hs_reg   <= hs_raw;
         s1_vs_reg   <= vs_raw;
         vid_de_reg  <= s1_de_reg;
         vid_hs_reg  <= s1_hs_reg ~^ SYNC_POL;
         vid_vs_reg  <= s1_vs_reg ~^ SYNC_POL;
         vid_rgb_reg <= rgb_next;
      end
   end

   // ------------------------------------------------------------- underflow
   // A clear that lands on a miss still records that miss.
   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         underflow_reg     <= 1'b0;
         underflow_cnt_reg <= '0;
      end else if (underflow_clr) begin
         underflow_reg     <= miss;
         underflow_cnt_reg <= {15'd0, miss};
      end else if (miss) begin
         underflow_reg <= 1'b1;
         if (underflow_cnt_reg != 16'hFFFF) begin
            underflow_cnt_reg <= underflow_cnt_reg + 16'd1;
         end
      end
   end

   assign vid_hs        = vid_hs_reg;
   assign vid_vs        = vid_vs_reg;
   assign vid_de        = vid_de_reg;
   assign vid_rgb       = vid_rgb_reg;
   assign underflow     = underflow_reg;
   assign underflow_cnt = underflow_cnt_reg;

endmodule

// File: tb/tb_video_fifo_pixel_out.sv
// Bench for video_fifo_pixel_out: raster-position reference model plus a FIFO queue model,
// compared every cycle, with directed frame-level checks.
module tb_video_fifo_pixel_out;

   localparam int H_ACTIVE = 8;
   localparam int H_FP     = 2;
   localparam int H_SYNC   = 2;
   localparam int H_BP     = 2;
   localparam int V_ACTIVE = 4;
   localparam int V_FP     = 1;
   localparam int V_SYNC   = 1;
   localparam int V_BP     = 1;
   localparam bit TB_POL   = 1'b1;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FRAME    = H_TOTAL * V_TOTAL;
   localparam int FIRST_ACT = (V_TOTAL - V_ACTIVE) * H_TOTAL;

   localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic [23:0] rgb;
   } pix_t;

   logic        rd_clk;
   logic        rd_rst_n;
   logic        rd_en;
   logic [15:0] rd_data;
   logic        rd_empty;
   logic        frame_req;
   logic        test_mode;
   logic        underflow_clr;
   logic        vid_hs, vid_vs, vid_de;
   logic [23:0] vid_rgb;
   logic        underflow;
   logic [15:0] underflow_cnt;

   int          checks, failures;
   int          p;
   logic        m_uf;
   int          m_cnt;
   bit          m_pat;
   pix_t        hist[$];
   logic [15:0] fifo_q[$];
   int          n_rd, n_de, n_hs;

   video_fifo_pixel_out #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .SYNC_POL(TB_POL)
   ) dut (
      .rd_clk(rd_clk),
      .rd_rst_n(rd_rst_n),
      .rd_en(rd_en),
      .rd_data(rd_data),
      .rd_empty(rd_empty),
      .frame_req(frame_req),
      .test_mode(test_mode),
      .underflow_clr(underflow_clr),
      .vid_hs(vid_hs),
      .vid_vs(vid_vs),
      .vid_de(vid_de),
      .vid_rgb(vid_rgb),
      .underflow(underflow),
      .underflow_cnt(underflow_cnt)
   );

   initial rd_clk = 1'b0;
   always #5 rd_clk = ~rd_clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [23:0] exp565(input logic [15:0] w);
      int r, g, b;
      r = (w >> 11) & 31;
      g = (w >> 5) & 63;
      b = w & 31;
      return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
   endfunction

   function automatic pix_t idle_pix();
      pix_t e;
      e.de  = 1'b0;
      e.hs  = !TB_POL;
      e.vs  = !TB_POL;
      e.rgb = 24'h0;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      p     = 0;
      m_uf  = 1'b0;
      m_cnt = 0;
      m_pat = 1'b0;
      hist.delete();
      hist.push_back(idle_pix());
      hist.push_back(idle_pix());
   endtask

   task automatic load(input int n, input bit fixed);
      logic [15:0] w [3];
      w[0] = 16'hF800; w[1] = 16'h07E0; w[2] = 16'h001F;
      for (int i = 0; i < n; i++) begin
         if (fixed) fifo_q.push_back(w[i % 3]);
         else       fifo_q.push_back(16'($urandom));
      end
      rd_empty = (fifo_q.size() == 0);
   endtask

   // One clock: compare at the falling edge, advance the model, then act as the FIFO.
   task automatic cycle();
      int   h, v;
      bit   a, hsr, vsr, e_rd, e_fr, ms;
      pix_t e;
      logic took;
      @(negedge rd_clk);
      h    = p % H_TOTAL;
      v    = (V_ACTIVE + p / H_TOTAL) % V_TOTAL;
      a    = (h < H_ACTIVE) && (v < V_ACTIVE);
      hsr  = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
      vsr  = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
      e_rd = a && (fifo_q.size() != 0) && !m_pat;
      ms   = a && (fifo_q.size() == 0) && !m_pat;
      e_fr = (rd_rst_n === 1'b1) && (h == 0) && (v == V_ACTIVE);
      chk("rd_en", 32'(rd_en), 32'(e_rd));
      chk("frame_req", 32'(frame_req), 32'(e_fr));
      chk("vid_de", 32'(vid_de), 32'(hist[0].de));
      chk("vid_hs", 32'(vid_hs), 32'(hist[0].hs));
      chk("vid_vs", 32'(vid_vs), 32'(hist[0].vs));
      chk("vid_rgb", 32'(vid_rgb), 32'(hist[0].rgb));
      chk("underflow", 32'(underflow), 32'(m_uf));
      chk("underflow_cnt", 32'(underflow_cnt), 32'(m_cnt));
      took = rd_en;
      n_rd += int'(rd_en === 1'b1);
      n_de += int'(vid_de === 1'b1);
      n_hs += int'(vid_hs === 1'b1);
      if (rd_rst_n !== 1'b1) begin
         model_reset();
      end else begin
         e.de  = a;
         e.hs  = hsr ? TB_POL : !TB_POL;
         e.vs  = vsr ? TB_POL : !TB_POL;
         if (!a)         e.rgb = 24'h0;
         else if (m_pat) e.rgb = BARS[h * 8 / H_ACTIVE];
         else if (ms)    e.rgb = 24'h0;
         else            e.rgb = exp565(fifo_q[0]);
         hist.push_back(e);
         void'(hist.pop_front());
         if (underflow_clr) begin
            m_uf  = ms;
            m_cnt = ms ? 1 : 0;
         end else if (ms) begin
            m_uf = 1'b1;
            if (m_cnt < 65535) m_cnt++;
         end
`ifdef TEST_PATTERN_EN
         if (e_fr) m_pat = test_mode;
`endif
         p++;
      end
      @(posedge rd_clk);
      #1;
      if (took === 1'b1 && fifo_q.size() != 0) rd_data = fifo_q.pop_front();
      rd_empty = (fifo_q.size() == 0);
   endtask

   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (p < target && guard < 2000) begin
         cycle();
         guard++;
      end
   endtask

   initial begin
      int n;
      checks        = 0;
      failures      = 0;
      n_rd          = 0;
      n_de          = 0;
      n_hs          = 0;
      rd_rst_n      = 1'b0;
      rd_empty      = 1'b1;
      rd_data       = 16'h0;
      test_mode     = 1'b0;
      underflow_clr = 1'b0;
      @(posedge rd_clk);
      #1;
      model_reset();

      // Reset held: idle outputs, no frame request.
      load(32, 1'b1);
      cycle();
      cycle();
      rd_rst_n = 1'b1;

      // Frame 1: full FIFO, first de 44 cycles after the frame request.
      n_rd = 0;
      n = 0;
      while (vid_de !== 1'b1 && n < 200) begin
         cycle();
         n++;
      end
      chk("first_de_delay", 32'(n), 32'(FIRST_ACT + 2));
      run_to(FRAME);
      chk("frame1_reads", 32'(n_rd), 32'(H_ACTIVE * V_ACTIVE));
      chk("frame1_underflow", 32'(underflow), 32'd0);

      // Frame 2: only 5 words, the remaining 27 pixels underflow.
      load(5, 1'b0);
      n_rd = 0; n_de = 0; n_hs = 0;
      run_to(2 * FRAME);
      chk("frame2_reads", 32'(n_rd), 32'd5);
      chk("frame2_de", 32'(n_de), 32'(H_ACTIVE * V_ACTIVE));
      chk("frame2_hs_high", 32'(n_hs), 32'(H_SYNC * V_TOTAL));
      chk("frame2_underflow", 32'(underflow), 32'd1);
      chk("frame2_ucnt", 32'(underflow_cnt), 32'd27);

      // Frame 3: empty throughout.
      run_to(3 * FRAME);
      chk("frame3_ucnt", 32'(underflow_cnt), 32'd59);

      // Clear coinciding with the first miss of frame 4.
      run_to(3 * FRAME + FIRST_ACT);
      underflow_clr = 1'b1;
      cycle();
      underflow_clr = 1'b0;
      chk("clr_on_miss_flag", 32'(underflow), 32'd1);
      chk("clr_on_miss_cnt", 32'(underflow_cnt), 32'd1);
      run_to(4 * FRAME);

      // Saturation: preset near the top, then a whole frame of misses.
      force dut.underflow_cnt_reg = 16'hFFFE;
      #1;
      release dut.underflow_cnt_reg;
      m_cnt = 65534;
      run_to(5 * FRAME);
      chk("ucnt_saturated", 32'(underflow_cnt), 32'h0000FFFF);
      underflow_clr = 1'b1;
      cycle();
      underflow_clr = 1'b0;
      chk("clr_blank_flag", 32'(underflow), 32'd0);
      chk("clr_blank_cnt", 32'(underflow_cnt), 32'd0);

      // Reset in the middle of an active line.
      load(32, 1'b0);
      run_to(6 * FRAME + FIRST_ACT + H_TOTAL + 3);
      rd_rst_n = 1'b0;
      cycle();
      chk("rst_mid_de", 32'(vid_de), 32'd0);
      chk("rst_mid_rd_en", 32'(rd_en), 32'd0);
      chk("rst_mid_rgb", 32'(vid_rgb), 32'd0);
      chk("rst_mid_frame_req", 32'(frame_req), 32'd0);
      fifo_q.delete();
      rd_empty = 1'b1;
      rd_rst_n = 1'b1;
      #1;
      chk("frame_req_after_release", 32'(frame_req), 32'd1);
      load(32, 1'b0);
      run_to(FRAME);
      chk("post_reset_underflow", 32'(underflow), 32'd0);

`ifdef TEST_PATTERN_EN
      // Colour bars for one frame: no reads, no underflow, data left untouched.
      test_mode = 1'b1;
      load(8, 1'b0);
      n_rd = 0;
      run_to(FRAME + FIRST_ACT + 3);
      chk("bar1_yellow", 32'(vid_rgb), 32'h00FFFF00);
      run_to(2 * FRAME);
      test_mode = 1'b0;
      chk("pattern_reads", 32'(n_rd), 32'd0);
      chk("pattern_underflow", 32'(underflow), 32'd0);
      run_to(3 * FRAME);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
